// File: rtl/z80_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : z80_bus_pkg
// Purpose  : Shared types and widths for the Z80 bus arbiter and its
//            interface: bus widths and the arbiter state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package z80_bus_pkg;

   localparam int Z80_ADDR_W = 16;
   localparam int Z80_DATA_W = 8;

   typedef enum logic [2:0] {
      ARB_IDLE    = 3'd0,  // CPU owns the bus
      ARB_REQ     = 3'd1,  // BUSREQ_L asserted, waiting for BUSACK_L
      ARB_GRANT   = 3'd2,  // one master drives the bus
      ARB_RELEASE = 3'd3,  // bus floated to inactive, BUSREQ_L dropped
      ARB_UNACK   = 3'd4   // waiting for the CPU to drop BUSACK_L
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/z80_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : z80_bus_arbiter_if
// Purpose  : Bundles the CPU bus, the DMA master requests/buses, the
//            BUSREQ_L/BUSACK_L handshake and the muxed system bus.
// Modports : master - the CPU and DMA masters side (drives requests and
//                     source buses, observes grant and muxed bus)
//            slave  - the arbiter side
// Revision : 1.0 - initial release
// ============================================================================
interface z80_bus_arbiter_if #(
   parameter int NUM_REQ = 2
);
   import z80_bus_pkg::*;

   // CPU side
   logic [Z80_ADDR_W-1:0]         cpu_addr;
   logic [Z80_DATA_W-1:0]         cpu_data;
   logic                          cpu_MREQ_L;
   logic                          cpu_IORQ_L;
   logic                          cpu_RD_L;
   logic                          cpu_WR_L;
   logic                          BUSREQ_L;
   logic                          BUSACK_L;

   // DMA masters
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ-1:0]            done;
   logic [NUM_REQ*Z80_ADDR_W-1:0] dma_addr;
   logic [NUM_REQ*Z80_DATA_W-1:0] dma_data;
   logic [NUM_REQ-1:0]            dma_rd;
   logic [NUM_REQ-1:0]            dma_wr;
   logic [NUM_REQ-1:0]            dma_io;
   logic [NUM_REQ-1:0]            gnt;

   // Muxed bus towards memory/ports
   logic [Z80_ADDR_W-1:0]         addr_bus;
   logic [Z80_DATA_W-1:0]         data_out;
   logic                          MREQ_L;
   logic                          IORQ_L;
   logic                          RD_L;
   logic                          WR_L;

   modport master (
      output cpu_addr, cpu_data, cpu_MREQ_L, cpu_IORQ_L, cpu_RD_L, cpu_WR_L,
      output BUSACK_L, req, done, dma_addr, dma_data, dma_rd, dma_wr, dma_io,
      input  BUSREQ_L, gnt, addr_bus, data_out, MREQ_L, IORQ_L, RD_L, WR_L
   );

   modport slave (
      input  cpu_addr, cpu_data, cpu_MREQ_L, cpu_IORQ_L, cpu_RD_L, cpu_WR_L,
      input  BUSACK_L, req, done, dma_addr, dma_data, dma_rd, dma_wr, dma_io,
      output BUSREQ_L, gnt, addr_bus, data_out, MREQ_L, IORQ_L, RD_L, WR_L
   );

endinterface
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Purpose  : Combinational round-robin pick: the first set request at or
//            after ptr, wrapping around. Shared with the interrupt-source
//            arbiter.
// Ports    : req   in  N        request vector
//            ptr   in  PW       search start position (0..N-1)
//            pick  out N        one-hot chosen request (0 when none)
//            valid out 1        at least one request set
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
   parameter int N = 2
) (
   input  wire logic [N-1:0]                         req,
   input  wire logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
   output logic      [N-1:0]                         pick,
   output logic                                      valid
);

   always_comb begin
      pick  = '0;
      valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = int'(ptr) + k;
         if (j >= N) begin
            j = j - N;
         end
         if (!valid && req[j]) begin
            pick[j] = 1'b1;
            valid   = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/z80_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : z80_bus_arbiter
// Purpose  : Shares the Z80 system bus between the CPU and NUM_REQ DMA
//            masters. Takes the bus via BUSREQ_L/BUSACK_L, grants one master
//            at a time round-robin, limits each grant to MAX_HOLD cycles and
//            always hands the bus back to the CPU for at least
//            CPU_MIN_CYCLES between takeovers.
// Ports    : clk  in  1   system clock
//            rst  in  1   synchronous reset, active-high
//            bus  slave modport of z80_bus_arbiter_if (CPU bus, handshake,
//                 DMA requests/buses, one-hot gnt, muxed system bus)
// Revision : 1.0 - initial release
// ============================================================================
module z80_bus_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int MAX_HOLD       = 64,
   parameter int CPU_MIN_CYCLES = 4
) (
   input  wire logic        clk,
   input  wire logic        rst,
   z80_bus_arbiter_if.slave bus
);
   import z80_bus_pkg::*;

   localparam int SEL_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int HOLD_W = $clog2(MAX_HOLD);
   localparam int CPU_W  = $clog2(CPU_MIN_CYCLES + 1);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [CPU_W-1:0]  CPU_MIN   = CPU_W'(CPU_MIN_CYCLES);
   localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_REQ - 1);

   arb_state_t         state_q,    state_d;
   logic               busreq_l_q, busreq_l_d;
   logic [NUM_REQ-1:0] gnt_q,      gnt_d;
   logic [SEL_W-1:0]   rr_ptr_q,   rr_ptr_d;
   logic [SEL_W-1:0]   sel_q,      sel_d;
   logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic [CPU_W-1:0]   cpu_cnt_q,  cpu_cnt_d;

   logic [NUM_REQ-1:0] w_pick;
   logic               w_pick_valid;
   logic [SEL_W-1:0]   w_pick_idx;
   logic               w_sel_req;
   logic               w_sel_done;

   rr_picker #(
      .N (NUM_REQ)
   ) u_rr_picker (
      .req   (bus.req),
      .ptr   (rr_ptr_q),
      .pick  (w_pick),
      .valid (w_pick_valid)
   );

   // One-hot to index for the sel register.
   always_comb begin
      w_pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_pick[i]) begin
            w_pick_idx = SEL_W'(i);
         end
      end
   end

   // Only the selected master's request and release pulse matter.
   assign w_sel_req  = bus.req[sel_q];
   assign w_sel_done = bus.done[sel_q];

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB_IDLE;
         busreq_l_q <= 1'b1;
         gnt_q      <= '0;
         rr_ptr_q   <= '0;
         sel_q      <= '0;
         hold_cnt_q <= '0;
         // Start saturated so the first request after reset is not delayed.
         cpu_cnt_q  <= CPU_MIN;
      end else begin
         state_q    <= state_d;
         busreq_l_q <= busreq_l_d;
         gnt_q      <= gnt_d;
         rr_ptr_q   <= rr_ptr_d;
         sel_q      <= sel_d;
         hold_cnt_q <= hold_cnt_d;
         cpu_cnt_q  <= cpu_cnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      busreq_l_d = busreq_l_q;
      gnt_d      = gnt_q;
      rr_ptr_d   = rr_ptr_q;
      sel_d      = sel_q;
      hold_cnt_d = hold_cnt_q;
      cpu_cnt_d  = cpu_cnt_q;

      case (state_q)
         ARB_IDLE: begin
            // BUSACK_L is not looked at here: a spurious ack never grants.
            if (cpu_cnt_q < CPU_MIN) begin
               cpu_cnt_d = cpu_cnt_q + CPU_W'(1);
            end
            if (w_pick_valid && (cpu_cnt_q >= CPU_MIN)) begin
               sel_d      = w_pick_idx;
               busreq_l_d = 1'b0;
               state_d    = ARB_REQ;
            end
         end

         ARB_REQ: begin
            if (!bus.BUSACK_L) begin
               if (w_sel_req) begin
                  gnt_d        = '0;
                  gnt_d[sel_q] = 1'b1;
                  hold_cnt_d   = '0;
                  state_d      = ARB_GRANT;
               end else begin
                  // Requester withdrew while we waited: hand the bus back
                  // without ever granting it.
                  busreq_l_d = 1'b1;
                  state_d    = ARB_RELEASE;
               end
            end
         end

         ARB_GRANT: begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            // All release causes collapse into a single transition, so a
            // done coinciding with the hold limit releases only once.
            if (w_sel_done || !w_sel_req || (hold_cnt_q == HOLD_LAST)) begin
               gnt_d      = '0;
               busreq_l_d = 1'b1;
               state_d    = ARB_RELEASE;
            end
         end

         ARB_RELEASE: begin
            busreq_l_d = 1'b1;
            rr_ptr_d   = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
            state_d    = ARB_UNACK;
         end

         ARB_UNACK: begin
            if (bus.BUSACK_L) begin
               cpu_cnt_d = '0;
               state_d   = ARB_IDLE;
            end
         end

         default: begin
            busreq_l_d = 1'b1;
            gnt_d      = '0;
            state_d    = ARB_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output logic: bus mux
   // ------------------------------------------------------------------------
   always_comb begin
      bus.addr_bus = bus.cpu_addr;
      bus.data_out = bus.cpu_data;
      bus.MREQ_L   = bus.cpu_MREQ_L;
      bus.IORQ_L   = bus.cpu_IORQ_L;
      bus.RD_L     = bus.cpu_RD_L;
      bus.WR_L     = bus.cpu_WR_L;

      case (state_q)
         ARB_GRANT: begin
            bus.addr_bus = bus.dma_addr[Z80_ADDR_W*sel_q +: Z80_ADDR_W];
            bus.data_out = bus.dma_data[Z80_DATA_W*sel_q +: Z80_DATA_W];
            // The space strobe follows whichever of rd/wr is active.
            bus.MREQ_L   = ~((bus.dma_rd[sel_q] | bus.dma_wr[sel_q]) & ~bus.dma_io[sel_q]);
            bus.IORQ_L   = ~((bus.dma_rd[sel_q] | bus.dma_wr[sel_q]) &  bus.dma_io[sel_q]);
            bus.RD_L     = ~bus.dma_rd[sel_q];
            bus.WR_L     = ~bus.dma_wr[sel_q];
         end
         ARB_RELEASE: begin
            bus.addr_bus = '0;
            bus.data_out = '0;
            bus.MREQ_L   = 1'b1;
            bus.IORQ_L   = 1'b1;
            bus.RD_L     = 1'b1;
            bus.WR_L     = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign bus.BUSREQ_L = busreq_l_q;
   assign bus.gnt      = gnt_q;

endmodule
`default_nettype wire

// File: tb/tb_z80_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_z80_bus_arbiter
// Purpose  : Directed self-checking bench for z80_bus_arbiter; the bench
//            plays the Z80 (BUSACK_L) and the DMA masters by hand.
// Revision : 1.0 - initial release
// ============================================================================
module tb_z80_bus_arbiter;
   import z80_bus_pkg::*;

   localparam int NUM_REQ        = 2;
   localparam int MAX_HOLD       = 64;
   localparam int CPU_MIN_CYCLES = 4;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   z80_bus_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   z80_bus_arbiter #(
      .NUM_REQ        (NUM_REQ),
      .MAX_HOLD       (MAX_HOLD),
      .CPU_MIN_CYCLES (CPU_MIN_CYCLES)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_defaults();
      bus.cpu_addr   = 16'h1234;
      bus.cpu_data   = 8'h5A;
      bus.cpu_MREQ_L = 1'b0;
      bus.cpu_IORQ_L = 1'b1;
      bus.cpu_RD_L   = 1'b0;
      bus.cpu_WR_L   = 1'b1;
      bus.BUSACK_L   = 1'b1;
      bus.req        = '0;
      bus.done       = '0;
      bus.dma_addr   = {16'h8001, 16'hC000};
      bus.dma_data   = {8'h3C, 8'hA5};
      bus.dma_rd     = '0;
      bus.dma_wr     = '0;
      bus.dma_io     = '0;
   endtask

   // Bounded wait for the arbiter to request the bus; n = cycles waited.
   task automatic wait_busreq(input int limit, output int n);
      n = 0;
      while (bus.BUSREQ_L !== 1'b0 && n < limit) begin
         tick();
         n++;
      end
      total++;
      if (bus.BUSREQ_L !== 1'b0) begin
         bad++;
         $display("FAIL busreq_timeout: BUSREQ_L=%b after %0d cycles, want 0", bus.BUSREQ_L, n);
      end
   endtask

   task automatic test_reset();
      set_defaults();
      rst = 1'b1;
      repeat (3) tick();
      total++; if (bus.BUSREQ_L !== 1'b1) begin bad++; $display("FAIL reset_busreq: got %b want 1", bus.BUSREQ_L); end
      total++; if (bus.gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b want 00", bus.gnt); end
      total++; if (bus.addr_bus !== 16'h1234) begin bad++; $display("FAIL reset_addr: got %h want 1234", bus.addr_bus); end
      total++; if (bus.data_out !== 8'h5A) begin bad++; $display("FAIL reset_data: got %h want 5a", bus.data_out); end
      total++;
      if ({bus.MREQ_L, bus.IORQ_L, bus.RD_L, bus.WR_L} !== 4'b0101) begin
         bad++; $display("FAIL reset_ctrl: got %b want 0101", {bus.MREQ_L, bus.IORQ_L, bus.RD_L, bus.WR_L});
      end
      rst = 1'b0;
   endtask

   task automatic test_single_take();
      repeat (4) tick();
      bus.req    = 2'b01;
      bus.dma_wr = 2'b01;
      tick();
      total++; if (bus.BUSREQ_L !== 1'b0) begin bad++; $display("FAIL single_busreq: got %b want 0", bus.BUSREQ_L); end
      total++; if (bus.gnt !== 2'b00) begin bad++; $display("FAIL single_gnt_before_ack: got %b want 00", bus.gnt); end
      total++; if (bus.addr_bus !== 16'h1234) begin bad++; $display("FAIL single_req_passthru: got %h want 1234", bus.addr_bus); end
      tick();
      total++; if (bus.BUSREQ_L !== 1'b0) begin bad++; $display("FAIL single_busreq_hold: got %b want 0", bus.BUSREQ_L); end
      bus.BUSACK_L = 1'b0;
      tick();
      total++; if (bus.gnt !== 2'b01) begin bad++; $display("FAIL single_gnt: got %b want 01", bus.gnt); end
      total++; if (bus.addr_bus !== 16'hC000) begin bad++; $display("FAIL single_addr: got %h want c000", bus.addr_bus); end
      total++; if (bus.data_out !== 8'hA5) begin bad++; $display("FAIL single_data: got %h want a5", bus.data_out); end
      total++;
      if ({bus.MREQ_L, bus.IORQ_L, bus.RD_L, bus.WR_L} !== 4'b0110) begin
         bad++; $display("FAIL single_ctrl: got %b want 0110", {bus.MREQ_L, bus.IORQ_L, bus.RD_L, bus.WR_L});
      end
      // done from a non-selected master is ignored
      bus.done = 2'b10;
      tick();
      total++; if (bus.gnt !== 2'b01) begin bad++; $display("FAIL single_foreign_done: got %b want 01", bus.gnt); end
      bus.done = 2'b01;
      tick();
      bus.done = 2'b00;
      total++; if (bus.gnt !== 2'b00) begin bad++; $display("FAIL single_release_gnt: got %b want 00", bus.gnt); end
      total++; if (bus.BUSREQ_L !== 1'b1) begin bad++; $display("FAIL single_release_busreq: got %b want 1", bus.BUSREQ_L); end
      total++;
      if (bus.addr_bus !== 16'h0000 || {bus.MREQ_L, bus.IORQ_L, bus.RD_L, bus.WR_L} !== 4'b1111) begin
         bad++; $display("FAIL single_release_bus: addr %h ctrl %b want 0000 1111",
                         bus.addr_bus, {bus.MREQ_L, bus.IORQ_L, bus.RD_L, bus.WR_L});
      end
      bus.req    = 2'b00;
      bus.dma_wr = 2'b00;
      tick();
      total++; if (bus.addr_bus !== 16'h1234) begin bad++; $display("FAIL single_unack_passthru: got %h want 1234", bus.addr_bus); end
      bus.BUSACK_L = 1'b1;
      tick();
   endtask

   task automatic test_round_robin();
      logic [1:0] exp;
      int n;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.req = 2'b11;
      for (int g = 0; g < 4; g++) begin
         exp = (g % 2 == 0) ? 2'b01 : 2'b10;
         wait_busreq(20, n);
         // After a release: RELEASE, UNACK, then 5 IDLE cycles (cpu_cnt 0..4).
         total++;
         if (n !== ((g == 0) ? 1 : 7)) begin
            bad++; $display("FAIL rr_gap[%0d]: got %0d cycles want %0d", g, n, (g == 0) ? 1 : 7);
         end
         bus.BUSACK_L = 1'b0;
         tick();
         total++; if (bus.gnt !== exp) begin bad++; $display("FAIL rr_order[%0d]: got %b want %b", g, bus.gnt, exp); end
         tick();
         tick();
         bus.done = exp;
         tick();
         bus.done = 2'b00;
         total++; if (bus.gnt !== 2'b00) begin bad++; $display("FAIL rr_release[%0d]: got %b want 00", g, bus.gnt); end
         bus.BUSACK_L = 1'b1;
      end
      bus.req = 2'b00;
      repeat (8) tick();
   endtask

   task automatic test_hold_limit();
      int n;
      int cnt;
      bus.req    = 2'b10;
      bus.dma_rd = 2'b10;
      bus.dma_io = 2'b10;
      wait_busreq(20, n);
      bus.BUSACK_L = 1'b0;
      tick();
      total++; if (bus.addr_bus !== 16'h8001) begin bad++; $display("FAIL io_addr: got %h want 8001", bus.addr_bus); end
      total++;
      if ({bus.MREQ_L, bus.IORQ_L, bus.RD_L, bus.WR_L} !== 4'b1001) begin
         bad++; $display("FAIL io_ctrl: got %b want 1001", {bus.MREQ_L, bus.IORQ_L, bus.RD_L, bus.WR_L});
      end
      cnt = 0;
      while (bus.gnt === 2'b10 && cnt < 100) begin
         cnt++;
         tick();
      end
      total++; if (cnt !== MAX_HOLD) begin bad++; $display("FAIL hold_len: got %0d cycles want %0d", cnt, MAX_HOLD); end
      total++; if (bus.BUSREQ_L !== 1'b1) begin bad++; $display("FAIL hold_busreq: got %b want 1", bus.BUSREQ_L); end
      bus.req      = 2'b00;
      bus.dma_rd   = 2'b00;
      bus.dma_io   = 2'b00;
      bus.BUSACK_L = 1'b1;
      repeat (8) tick();
   endtask

   task automatic test_withdraw();
      int n;
      bus.req = 2'b01;
      wait_busreq(20, n);
      bus.req = 2'b00;
      tick();
      total++; if (bus.BUSREQ_L !== 1'b0) begin bad++; $display("FAIL wd_busreq_hold: got %b want 0", bus.BUSREQ_L); end
      bus.BUSACK_L = 1'b0;
      tick();
      total++; if (bus.gnt !== 2'b00) begin bad++; $display("FAIL wd_gnt: got %b want 00", bus.gnt); end
      total++; if (bus.BUSREQ_L !== 1'b1) begin bad++; $display("FAIL wd_busreq: got %b want 1", bus.BUSREQ_L); end
      bus.BUSACK_L = 1'b1;
      tick();
      tick();
      total++; if (bus.gnt !== 2'b00) begin bad++; $display("FAIL wd_gnt_late: got %b want 00", bus.gnt); end
      repeat (6) tick();
   endtask

   task automatic test_spurious_ack();
      bus.BUSACK_L = 1'b0;
      repeat (3) tick();
      total++; if (bus.BUSREQ_L !== 1'b1) begin bad++; $display("FAIL spur_busreq: got %b want 1", bus.BUSREQ_L); end
      total++; if (bus.gnt !== 2'b00) begin bad++; $display("FAIL spur_gnt: got %b want 00", bus.gnt); end
      total++; if (bus.addr_bus !== 16'h1234) begin bad++; $display("FAIL spur_passthru: got %h want 1234", bus.addr_bus); end
      bus.BUSACK_L = 1'b1;
      tick();
   endtask

   task automatic test_mid_reset();
      int n;
      bus.req = 2'b10;
      wait_busreq(20, n);
      bus.BUSACK_L = 1'b0;
      tick();
      repeat (9) tick();
      total++; if (bus.gnt !== 2'b10) begin bad++; $display("FAIL mr_gnt_cycle10: got %b want 10", bus.gnt); end
      rst = 1'b1;
      tick();
      total++; if (bus.gnt !== 2'b00) begin bad++; $display("FAIL mr_gnt: got %b want 00", bus.gnt); end
      total++; if (bus.BUSREQ_L !== 1'b1) begin bad++; $display("FAIL mr_busreq: got %b want 1", bus.BUSREQ_L); end
      total++;
      if (bus.addr_bus !== 16'h1234 || bus.MREQ_L !== 1'b0 || bus.RD_L !== 1'b0) begin
         bad++; $display("FAIL mr_passthru: addr %h MREQ_L %b RD_L %b want 1234 0 0",
                         bus.addr_bus, bus.MREQ_L, bus.RD_L);
      end
      rst          = 1'b0;
      bus.req      = 2'b00;
      bus.BUSACK_L = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_take();
      test_round_robin();
      test_hold_limit();
      test_withdraw();
      test_spurious_ack();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
`default_nettype wire
